// File: rtl/mux_32_to_1.sv
// 32:1 WIDTH-bit word selector with a combinational output and a one-cycle registered copy.
// Optional build macro MUX_PARITY_EN adds combinational and registered parity outputs.
module mux_32_to_1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic [WIDTH-1:0] d8,
  input  logic [WIDTH-1:0] d9,
  input  logic [WIDTH-1:0] d10,
  input  logic [WIDTH-1:0] d11,
  input  logic [WIDTH-1:0] d12,
  input  logic [WIDTH-1:0] d13,
  input  logic [WIDTH-1:0] d14,
  input  logic [WIDTH-1:0] d15,
  input  logic [WIDTH-1:0] d16,
  input  logic [WIDTH-1:0] d17,
  input  logic [WIDTH-1:0] d18,
  input  logic [WIDTH-1:0] d19,
  input  logic [WIDTH-1:0] d20,
  input  logic [WIDTH-1:0] d21,
  input  logic [WIDTH-1:0] d22,
  input  logic [WIDTH-1:0] d23,
  input  logic [WIDTH-1:0] d24,
  input  logic [WIDTH-1:0] d25,
  input  logic [WIDTH-1:0] d26,
  input  logic [WIDTH-1:0] d27,
  input  logic [WIDTH-1:0] d28,
  input  logic [WIDTH-1:0] d29,
  input  logic [WIDTH-1:0] d30,
  input  logic [WIDTH-1:0] d31,
  input  logic [4:0]       s,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] y_r_o,
  output logic [4:0]       s_r_o
`ifdef MUX_PARITY_EN
  ,
  output logic             p_o,
  output logic             p_r_o
`endif
);

  logic [WIDTH-1:0] d_arr [32];
  logic [WIDTH-1:0] y_p0;
  logic [WIDTH-1:0] y_p1;
  logic [4:0]       s_p1;

  assign d_arr = '{d0,  d1,  d2,  d3,  d4,  d5,  d6,  d7,
                   d8,  d9,  d10, d11, d12, d13, d14, d15,
                   d16, d17, d18, d19, d20, d21, d22, d23,
                   d24, d25, d26, d27, d28, d29, d30, d31};

  // Stage p0: combinational select, every 5-bit code maps to a real input
  assign y_p0 = d_arr[s];
  assign y_o  = y_p0;

  // Stage p1: registered copy of the selected word and the index that chose it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_p1 <= '0;
      s_p1 <= '0;
    end else begin
      y_p1 <= y_p0;
      s_p1 <= s;
    end
  end

  assign y_r_o = y_p1;
  assign s_r_o = s_p1;

`ifdef MUX_PARITY_EN
  logic par_p1;

  assign p_o = ^y_p0;

  always_ff @(posedge clk_i) begin
    if (rst_i) par_p1 <= 1'b0;
    else       par_p1 <= ^y_p0;
  end

  assign p_r_o = par_p1;
`endif

endmodule

// File: tb/tb_mux_32_to_1.sv
// Directed and randomized checks of mux_32_to_1 against an array-indexing reference model.
// Parity checks are compiled in when MUX_PARITY_EN is defined.
module tb_mux_32_to_1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] d [32];
  logic [4:0]  s = '0;
  logic [31:0] y_o, y_r_o;
  logic [4:0]  s_r_o;
`ifdef MUX_PARITY_EN
  logic        p_o, p_r_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_y;
  logic [4:0]  exp_s;
`ifdef MUX_PARITY_EN
  logic        exp_p;
`endif

  always #5 clk = ~clk;

  mux_32_to_1 #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .d0(d[0]),   .d1(d[1]),   .d2(d[2]),   .d3(d[3]),
    .d4(d[4]),   .d5(d[5]),   .d6(d[6]),   .d7(d[7]),
    .d8(d[8]),   .d9(d[9]),   .d10(d[10]), .d11(d[11]),
    .d12(d[12]), .d13(d[13]), .d14(d[14]), .d15(d[15]),
    .d16(d[16]), .d17(d[17]), .d18(d[18]), .d19(d[19]),
    .d20(d[20]), .d21(d[21]), .d22(d[22]), .d23(d[23]),
    .d24(d[24]), .d25(d[25]), .d26(d[26]), .d27(d[27]),
    .d28(d[28]), .d29(d[29]), .d30(d[30]), .d31(d[31]),
    .s(s), .y_o(y_o), .y_r_o(y_r_o), .s_r_o(s_r_o)
`ifdef MUX_PARITY_EN
    , .p_o(p_o), .p_r_o(p_r_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_sel(input logic [4:0] idx);
    return d[int'(idx)];
  endfunction

  initial begin
    for (int k = 0; k < 32; k++) d[k] = 32'hA000_0000 + k;

    // Combinational sweep of every select code
    for (int k = 0; k < 32; k++) begin
      s = 5'(k);
      #5;
      chk("sweep_y", y_o, 32'hA000_0000 + k);
    end

    // Synchronous reset with s = 5
    @(negedge clk);
    rst = 1'b1;
    s = 5'd5;
    #1 chk("rst_y_before_edge", y_o, 32'hA000_0005);
    @(posedge clk); #1;
    chk("rst_y_r", y_r_o, 32'h0);
    chk("rst_s_r", 32'(s_r_o), 32'd0);
    chk("rst_y_during", y_o, 32'hA000_0005);
`ifdef MUX_PARITY_EN
    chk("rst_p_r", 32'(p_r_o), 32'd0);
`endif

    // Release reset, capture d31
    @(negedge clk);
    rst = 1'b0;
    s = 5'd31;
    @(posedge clk); #1;
    chk("cap31_y_r", y_r_o, 32'hA000_001F);
    chk("cap31_s_r", 32'(s_r_o), 32'd31);
    s = 5'd0;
    #1;
    chk("s0_y_immediate", y_o, 32'hA000_0000);
    chk("s0_y_r_held", y_r_o, 32'hA000_001F);

    // Unselected input changes are invisible; selected ones propagate
    @(negedge clk);
    s = 5'd3;
    d[4] = 32'hFFFF_FFFF;
    #1 chk("unsel_d4", y_o, 32'hA000_0003);
    d[3] = 32'h1234_5678;
    #1 chk("sel_d3_y", y_o, 32'h1234_5678);
    @(posedge clk); #1;
    chk("sel_d3_y_r", y_r_o, 32'h1234_5678);
    chk("sel_d3_s_r", 32'(s_r_o), 32'd3);

`ifdef MUX_PARITY_EN
    @(negedge clk);
    d[3] = 32'hA000_0003;
    d[7] = 32'h0000_0007;
    s = 5'd7;
    #1 chk("par_d7", 32'(p_o), 32'd1);
    @(posedge clk); #1;
    chk("par_r_d7", 32'(p_r_o), 32'd1);
    @(negedge clk);
    s = 5'd3;
    #1 chk("par_d3", 32'(p_o), 32'd0);
    chk("par_r_hold", 32'(p_r_o), 32'd1);
    @(posedge clk); #1;
    chk("par_r_d3", 32'(p_r_o), 32'd0);
`endif

    // Randomized traffic
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      for (int k = 0; k < 32; k++) d[k] = $urandom;
      s = 5'($urandom_range(31));
      #1;
      exp_y = model_sel(s);
      exp_s = s;
      chk("rand_y", y_o, exp_y);
`ifdef MUX_PARITY_EN
      exp_p = ^exp_y;
      chk("rand_p", 32'(p_o), 32'(exp_p));
`endif
      @(posedge clk); #1;
      chk("rand_y_r", y_r_o, exp_y);
      chk("rand_s_r", 32'(s_r_o), 32'(exp_s));
`ifdef MUX_PARITY_EN
      chk("rand_p_r", 32'(p_r_o), 32'(exp_p));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
